// File: rtl/moldudp64_pkg.sv
// Shared widths and packet classes for the MoldUDP64 miss-detection path.
// The top module imports this for its parameter defaults and decode enum.
package moldudp64_pkg;

   localparam int SEQ_NUM_W_DEF = 64;
   localparam int SID_W_DEF     = 80;
   localparam int ML_W_DEF      = 16;

   typedef enum logic [2:0] {
      PKT_DROP,
      PKT_SEQ,
      PKT_EOS,
      PKT_SID_GAP,
      PKT_RESYNC
   } pkt_cls_e;

endpackage

// File: rtl/miss_msg_det.sv
// Tracks the expected MoldUDP64 session/sequence and reports gaps.
// One registered report per header, no stall between headers.
module miss_msg_det
   import moldudp64_pkg::*;
#(
   parameter int SEQ_NUM_W = SEQ_NUM_W_DEF,
   parameter int SID_W     = SID_W_DEF,
   parameter int ML_W      = ML_W_DEF,
   parameter logic [SID_W-1:0] SID_GAP_MAX =
      SID_W'(64'h8000_0000_0000_0000)
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 v_i,
   input  logic [SID_W-1:0]     sid_i,
   input  logic [SEQ_NUM_W-1:0] seq_num_i,
   input  logic [ML_W-1:0]      msg_cnt_i,
   input  logic                 eos_i,
   output logic                 miss_seq_num_v_o,
   output logic [SID_W-1:0]     miss_seq_num_sid_o,
   output logic [SEQ_NUM_W-1:0] miss_seq_num_start_o,
   output logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o,
   output logic                 miss_sid_v_o,
   output logic [SID_W-1:0]     miss_sid_start_o,
   output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_start_o,
   output logic [SID_W-1:0]     miss_sid_cnt_o,
   output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_end_o
);

   logic [SID_W-1:0]     sid_q;
   logic [SEQ_NUM_W-1:0] seq_q;

   logic                 sid_eq;
   logic                 sid_gt;
   logic                 sid_far;
   logic                 seq_gt;
   logic                 seq_lt;
   logic [SID_W-1:0]     sid_diff;
   logic [SEQ_NUM_W-1:0] seq_diff;
   logic [SEQ_NUM_W-1:0] nxt_seq;
   pkt_cls_e             cls;

   assign sid_eq   = (sid_i == sid_q);
   assign sid_gt   = (sid_i > sid_q);
   assign sid_diff = sid_i - sid_q;
   assign sid_far  = (sid_diff > SID_GAP_MAX);
   assign seq_gt   = (seq_num_i > seq_q);
   assign seq_lt   = (seq_num_i < seq_q);
   assign seq_diff = seq_num_i - seq_q;
   assign nxt_seq  = seq_num_i + SEQ_NUM_W'(msg_cnt_i)
                   + SEQ_NUM_W'(1);

   // Conditions are mutually exclusive; anything else is dropped.
   always_comb begin
      cls = PKT_DROP;
      if (v_i) begin
         unique case (1'b1)
            sid_eq && eos_i:            cls = PKT_EOS;
            sid_eq && !eos_i && !seq_lt: cls = PKT_SEQ;
            sid_gt && !sid_far:         cls = PKT_SID_GAP;
            sid_gt && sid_far:          cls = PKT_RESYNC;
            default:                    cls = PKT_DROP;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sid_q                    <= '0;
         seq_q                    <= '0;
         miss_seq_num_v_o         <= 1'b0;
         miss_seq_num_sid_o       <= '0;
         miss_seq_num_start_o     <= '0;
         miss_seq_num_cnt_o       <= '0;
         miss_sid_v_o             <= 1'b0;
         miss_sid_start_o         <= '0;
         miss_sid_seq_num_start_o <= '0;
         miss_sid_cnt_o           <= '0;
         miss_sid_seq_num_end_o   <= '0;
      end else begin
         miss_seq_num_v_o <= 1'b0;
         miss_sid_v_o     <= 1'b0;
         unique case (cls)
            PKT_SEQ, PKT_EOS: begin
               if (seq_gt) begin
                  miss_seq_num_v_o     <= 1'b1;
                  miss_seq_num_sid_o   <= sid_q;
                  miss_seq_num_start_o <= seq_q;
                  miss_seq_num_cnt_o   <= seq_diff;
               end
               if (cls == PKT_EOS) begin
                  sid_q <= sid_q + SID_W'(1);
                  seq_q <= '0;
               end else begin
                  seq_q <= nxt_seq;
               end
            end
            PKT_SID_GAP: begin
               miss_sid_v_o             <= 1'b1;
               miss_sid_start_o         <= sid_q;
               miss_sid_seq_num_start_o <= seq_q;
               miss_sid_cnt_o           <= sid_diff;
               miss_sid_seq_num_end_o   <= seq_num_i;
               sid_q                    <= sid_i;
               seq_q                    <= nxt_seq;
            end
            PKT_RESYNC: begin
               sid_q <= sid_i;
               seq_q <= nxt_seq;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_miss_msg_det.sv
// Scoreboard bench for miss_msg_det: model predicts each cycle's
// report and expected state, a monitor pops and compares.
module tb_miss_msg_det;

   localparam int SQ = 16;
   localparam int SD = 80;
   localparam int ML = 12;
   localparam logic [SD-1:0] GAPMAX = 80'h8000_0000_0000_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          v;
   logic [SD-1:0] sid;
   logic [SQ-1:0] seq;
   logic [ML-1:0] cnt;
   logic          eos;

   logic          sq_v;
   logic [SD-1:0] sq_sid;
   logic [SQ-1:0] sq_start;
   logic [SQ-1:0] sq_cnt;
   logic          sd_v;
   logic [SD-1:0] sd_start;
   logic [SQ-1:0] sd_sstart;
   logic [SD-1:0] sd_cnt;
   logic [SQ-1:0] sd_send;

   miss_msg_det #(
      .SEQ_NUM_W(SQ),
      .SID_W(SD),
      .ML_W(ML)
   ) dut (
      .clk(clk),
      .reset(reset),
      .v_i(v),
      .sid_i(sid),
      .seq_num_i(seq),
      .msg_cnt_i(cnt),
      .eos_i(eos),
      .miss_seq_num_v_o(sq_v),
      .miss_seq_num_sid_o(sq_sid),
      .miss_seq_num_start_o(sq_start),
      .miss_seq_num_cnt_o(sq_cnt),
      .miss_sid_v_o(sd_v),
      .miss_sid_start_o(sd_start),
      .miss_sid_seq_num_start_o(sd_sstart),
      .miss_sid_cnt_o(sd_cnt),
      .miss_sid_seq_num_end_o(sd_send)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          sv;
      logic [SD-1:0] ssid;
      logic [SQ-1:0] sstart;
      logic [SQ-1:0] scnt;
      logic          dv;
      logic [SD-1:0] dstart;
      logic [SQ-1:0] dsstart;
      logic [SD-1:0] dcnt;
      logic [SQ-1:0] dsend;
      logic [SD-1:0] sidq;
      logic [SQ-1:0] seqq;
   } exp_t;

   exp_t          sb[$];
   exp_t          last;
   logic [SD-1:0] m_sid;
   logic [SQ-1:0] m_seq;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: session/sequence rules applied to one header.
   task automatic issue(input logic vv, input logic [SD-1:0] s,
                        input logic [SQ-1:0] q,
                        input logic [ML-1:0] c, input logic e);
      exp_t          x;
      logic [SQ-1:0] nq;
      @(negedge clk);
      v = vv; sid = s; seq = q; cnt = c; eos = e;
      x = last;
      x.sv = 1'b0;
      x.dv = 1'b0;
      nq = q + SQ'(c) + SQ'(1);
      if (vv) begin
         if (s == m_sid) begin
            if (e || q >= m_seq) begin
               if (q > m_seq) begin
                  x.sv = 1'b1; x.ssid = m_sid;
                  x.sstart = m_seq; x.scnt = q - m_seq;
               end
               if (e) begin
                  m_sid = m_sid + SD'(1);
                  m_seq = '0;
               end else begin
                  m_seq = nq;
               end
            end
         end else if (s > m_sid) begin
            if (s - m_sid <= GAPMAX) begin
               x.dv = 1'b1; x.dstart = m_sid; x.dsstart = m_seq;
               x.dcnt = s - m_sid; x.dsend = q;
            end
            m_sid = s;
            m_seq = nq;
         end
      end
      x.sidq = m_sid;
      x.seqq = m_seq;
      last = x;
      sb.push_back(x);
   endtask

   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("seq_v", 128'(sq_v), 128'(x.sv));
            chk("seq_sid", 128'(sq_sid), 128'(x.ssid));
            chk("seq_start", 128'(sq_start), 128'(x.sstart));
            chk("seq_cnt", 128'(sq_cnt), 128'(x.scnt));
            chk("sid_v", 128'(sd_v), 128'(x.dv));
            chk("sid_start", 128'(sd_start), 128'(x.dstart));
            chk("sid_sstart", 128'(sd_sstart), 128'(x.dsstart));
            chk("sid_cnt", 128'(sd_cnt), 128'(x.dcnt));
            chk("sid_send", 128'(sd_send), 128'(x.dsend));
            chk("sid_q", 128'(dut.sid_q), 128'(x.sidq));
            chk("seq_q", 128'(dut.seq_q), 128'(x.seqq));
         end
      end
   end

   initial begin
      logic [SD-1:0] s;
      logic [SQ-1:0] q;
      logic [SQ-1:0] prev;
      int            k;
      int            n;
      last  = '{default: '0};
      m_sid = '0;
      m_seq = '0;
      reset = 1'b1;
      v = 1'b1; sid = SD'(5); seq = SQ'(9); cnt = ML'(1); eos = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sid_q", 128'(dut.sid_q), 128'(0));
      chk("rst_seq_q", 128'(dut.seq_q), 128'(0));
      chk("rst_seq_v", 128'(sq_v), 128'(0));
      chk("rst_sid_v", 128'(sd_v), 128'(0));
      chk("rst_sid_cnt", 128'(sd_cnt), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      v = 1'b0;

      issue(1, 0, 0, 5, 0);
      issue(1, 0, 6, 3, 0);
      issue(1, 0, 15, 0, 0);
      issue(0, 0, 0, 0, 0);
      issue(1, 0, 16, 0, 1);
      issue(1, 1, 0, 3, 0);
      issue(1, 3, 7, 2, 0);
      issue(1, 3, 2, 0, 0);
      issue(1, 0, 0, 0, 0);
      issue(1, 3, 14, 9, 1);
      issue(1, m_sid + GAPMAX, 1, 1, 0);
      issue(1, m_sid + GAPMAX + SD'(1), 5, 0, 0);

      for (int sess = 0; sess < 3; sess++) begin
         n = 0;
         do begin
            prev = m_seq;
            issue(1, m_sid, m_seq, ML'($urandom_range(0, 4095)), 0);
            n++;
         end while (m_seq >= prev && n < 2000);
         chk("wrap_seen", 128'(m_seq < prev), 128'(1));
         issue(1, m_sid, m_seq, ML'($urandom_range(0, 4095)), 1);
      end

      for (int i = 0; i < 400; i++) begin
         k = int'($urandom_range(0, 99));
         s = m_sid;
         if (k < 15)
            s = m_sid + SD'($urandom_range(1, 3));
         else if (k < 25)
            s = m_sid - SD'($urandom_range(1, 2));
         else if (k < 35)
            s = m_sid + GAPMAX - SD'(1) + SD'($urandom_range(0, 2));
         else if (k < 38)
            s = SD'({$urandom, $urandom, $urandom});
         k = int'($urandom_range(0, 9));
         q = m_seq;
         if (k >= 5 && k < 8)
            q = m_seq + SQ'($urandom_range(1, 20));
         else if (k >= 8)
            q = m_seq - SQ'($urandom_range(1, 20));
         issue($urandom_range(0, 4) != 0, s, q,
               ML'($urandom_range(0, 50)),
               $urandom_range(0, 9) == 0);
      end

      @(negedge clk);
      v = 1'b0;
      n = 0;
      while (sb.size() > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 128'(sb.size()), 128'(0));

      #2;
      reset = 1'b1;
      #1;
      chk("async_sid_q", 128'(dut.sid_q), 128'(0));
      chk("async_seq_q", 128'(dut.seq_q), 128'(0));
      chk("async_sid_start", 128'(sd_start), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/miss_msg_det.md
MISS_MSG_DET -- requirements
Module: miss_msg_det

Interface
REQ-001 SHALL have parameter SEQ_NUM_W, default 64: width of sequence numbers and sequence-gap counts.
REQ-002 SHALL have parameter SID_W, default 80: session-ID width.
REQ-003 SHALL have parameter ML_W, default 16: message-count width.
REQ-004 SHALL have parameter SID_GAP_MAX, SID_W bits, default 2^63: largest session gap reported as a miss.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port v_i, input, 1 bit: packet header valid this cycle.
REQ-008 SHALL have port sid_i, input, SID_W bits: packet session ID.
REQ-009 SHALL have port seq_num_i, input, SEQ_NUM_W bits: packet sequence number.
REQ-010 SHALL have port msg_cnt_i, input, ML_W bits: packet message count.
REQ-011 SHALL have port eos_i, input, 1 bit: end-of-session packet.
REQ-012 SHALL have outputs miss_seq_num_v_o (1), miss_seq_num_sid_o (SID_W), miss_seq_num_start_o (SEQ_NUM_W) and miss_seq_num_cnt_o (SEQ_NUM_W): sequence-gap report.
REQ-013 SHALL have outputs miss_sid_v_o (1), miss_sid_start_o (SID_W), miss_sid_seq_num_start_o (SEQ_NUM_W), miss_sid_cnt_o (SID_W) and miss_sid_seq_num_end_o (SEQ_NUM_W): session-gap report.

Function
REQ-014 SHALL hold registers sid_q (expected session) and seq_q (expected next sequence number); hierarchical names sid_q and seq_q are fixed for bench probing.
REQ-015 SHALL treat a cycle as idle when v_i=0: no state change, and both miss valids are 0 the next cycle.
REQ-016 When v_i=1 and sid_i==sid_q, SHALL classify the packet by seq_num_i:
- seq_num_i==seq_q: in order, no miss.
- seq_num_i>seq_q: gap.
- seq_num_i<seq_q: stale.
REQ-017 In-order or gap packet SHALL set seq_q <= seq_num_i + msg_cnt_i + 1; arithmetic is modulo 2^SEQ_NUM_W, with msg_cnt_i zero-extended.
REQ-018 Gap packet SHALL, one cycle later, pulse miss_seq_num_v_o=1 with sid=sid_q, start=old seq_q and cnt=seq_num_i-seq_q.
REQ-019 Stale packet (seq_num_i<seq_q) SHALL be ignored: no state change, no miss.
REQ-020 When v_i=1 and sid_i>sid_q with (sid_i-sid_q)<=SID_GAP_MAX, SHALL pulse miss_sid_v_o one cycle later with:
- start=sid_q
- seq_num_start=seq_q
- cnt=sid_i-sid_q
- seq_num_end=seq_num_i
It SHALL then set sid_q<=sid_i and seq_q<=seq_num_i+msg_cnt_i+1.
REQ-021 When v_i=1 and sid_i-sid_q>SID_GAP_MAX, SHALL resynchronise (sid_q<=sid_i, seq_q<=seq_num_i+msg_cnt_i+1) with no miss reported.
REQ-022 When v_i=1 and sid_i<sid_q, the packet SHALL be ignored.
REQ-023 When v_i=1, eos_i=1 and sid_i==sid_q, SHALL:
- report a sequence gap per REQ-018 if seq_num_i>seq_q;
- then set sid_q<=sid_q+1 and seq_q<=0, ignoring msg_cnt_i.
REQ-024 A session gap and a sequence gap SHALL never be reported for the same packet; the session path takes precedence.
REQ-025 All outputs SHALL be registered, with one-cycle latency from the v_i cycle; valids are single-cycle pulses; data fields hold their last value when the valid is 0.
REQ-026 Back-to-back valid packets on consecutive cycles SHALL be supported with no stall.

Reset
REQ-027 Assertion of reset SHALL asynchronously clear sid_q, seq_q, both valids and all data outputs to 0.
REQ-028 After reset, the first expected packet SHALL be sid 0, seq 0.
REQ-029 A packet presented during reset SHALL be discarded.

Structure
REQ-030 SEQ_NUM_W, SID_W and ML_W defaults SHALL live in shared package moldudp64_pkg.
REQ-031 The design SHALL be a single module with no sub-modules; the comparators and subtractors are inline.

Verification
REQ-032 Reset, then sid 0, seq 0, cnt 5 -> seq_q=6, sid_q=0, no miss.
REQ-033 Sid 0, seq 6, cnt 3 -> seq_q=10; then sid 0, seq 15, cnt 0 -> next cycle miss_seq_num_v_o=1, start=10, cnt=5, and seq_q=16.
REQ-034 With sid_q=0, seq_q=16, apply eos_i=1, seq 16 -> sid_q=1, seq_q=0, no miss; next sid 1, seq 0 is in order.
REQ-035 With sid_q=1, seq_q=4, apply sid 3, seq 7, cnt 2 -> miss_sid_v_o=1 with start=1, seq_num_start=4, cnt=2, seq_num_end=7; then sid_q=3, seq_q=10.
REQ-036 Apply stale seq 2 when seq_q=10, and separately sid 0 when sid_q=3 -> no miss, state unchanged.
REQ-037 Loop random cnt values until seq overflows, then send eos; repeat for 3 sessions -> zero misses, and seq_q/sid_q match the model after every packet.
